ternary_matvec_lanes: RTL and testbench
=======================================

// Module: ternary_matvec_lanes
// PURPOSE
//  Parametrised successor ternary matrix-vector unit: y = W*x, W DIM x DIM ternary, x/y fixed_point_t.
//  Snapshots x from vector memory, streams packed 2-bit weights from DDR (LANES per beat), accumulates
//  LANES products per cycle, writes y[r] back to vector memory row r. Sits beside the vector memory as an AFU.
// PARAMETERS
//  DIM        16  matrix/vector dimension; multiple of LANES
//  LANES       8  weights consumed per DDR beat, in bits [2*LANES-1:0]; 2*LANES <= $bits(ddr_data_t)
//  GUARD_W    $clog2(DIM)+1  accumulator guard bits above fixed_point_t width
// PORTS
//  clk_i            in   1       clock
//  rst_i            in   1       synchronous active-high reset
//  in_ready_o       out  1       high only in IDLE
//  in_valid_i       in   1       start request
//  matrix_memory_address_i in ddr_address_t  base of row-major packed W
//  done_o           out  1       one-cycle pulse with final write
//  vector_w_en_o    out  1       vector write strobe
//  vector_w_addr_o  out  DI_t    write index
//  vector_w_data_o  out  fixed_point_t  write data
//  vector_r_addr_o  out  DI_t    read index, data valid one cycle later
//  vector_r_data_i  in   fixed_point_t  read data
//  ddr_address_o    out  ddr_address_t  beat address
//  ddr_r_en_o       out  1       one-cycle read request
//  ddr_r_data_i     in   ddr_data_t     read data
//  ddr_r_valid_i    in   1       read data valid
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except in_ready_o=1; accumulator, counters, x buffer cleared.
//  Start: in_valid_i && in_ready_o latches base address; -> LOAD. Requests while busy ignored.
//  LOAD: issue vector_r_addr_o=0..DIM-1 on consecutive cycles; capture xbuf[i] one cycle later; DIM+1 cycles.
//  REQ: ddr_r_en_o=1 one cycle, ddr_address_o = base + r*(DIM/LANES) + b; -> WAIT. One outstanding read.
//  WAIT: ddr_address_o held; on ddr_r_valid_i: acc += sum_k tmul(w[k], xbuf[b*LANES+k]) same cycle;
//   b<DIM/LANES-1 -> REQ (b++); else -> WRITE. ddr_r_valid_i outside WAIT ignored.
//  WRITE: vector_w_en_o=1 one cycle, addr=r, data=result(acc); acc cleared; r<DIM-1 -> REQ (r++,b=0),
//   else done_o=1 same cycle -> IDLE. x snapshot makes in-place overwrite safe.
//  Weight code w[k]=ddr_r_data_i[2k+1:2k]: 00 -> 0, 01 -> +x, 11 -> -x, 10 -> 0 (reserved).
//  Arithmetic: products exact; acc signed $bits(fixed_point_t)+GUARD_W, no overflow internally.
//  Latency: DIM+1 + DIM*(DIM/LANES)*(1+Tddr) + DIM cycles, Tddr = request-to-valid cycles.
//  Reset mid-operation: immediate return to IDLE next edge; no further writes or DDR requests.
// CONFIGURATION
//  TERNARY_MATVEC_SATURATE_EN defined: result clamps acc to fixed_point_t max/min.
//  Undefined: result = low $bits(fixed_point_t) bits of acc (two's-complement wrap).
// STRUCTURE
//  config_pkg: ternary_t (2-bit enum ZERO/POS/NEG/RSVD), TERNARY_W=2, fixed-point max/min constants.
//  Sub-module ternary_mac_lanes: combinational LANES-wide ternary multiply + adder tree -> signed sum.
//  Top holds FSM (IDLE/LOAD/REQ/WAIT/WRITE), counters r,b,i, xbuf, accumulator.
// TESTING
//  W=I (01 on diagonal), x[i]=i -> y[i]=i, DIM writes, done_o with write of row 15.
//  W all 11, x all +1.0 -> every y = -16.0; all 00 -> all y = 0.
//  Row 0 all 01, x all max: SATURATE_EN -> y[0]=max; without -> wrapped low bits.
//  Random ternary W/x, Tddr random 1..5 cycles, stray ddr_r_valid_i in REQ -> matches golden model.
//  in_valid_i held high during run -> single run; rst_i during WAIT -> IDLE, no vector_w_en_o after.
//  Reserved code 10 in every weight -> all y = 0.

Source files
------------

// File: rtl/config_pkg.sv
// Shared types and constants for the ternary matrix-vector unit.
//   fixed_point_t : signed 16-bit Q8.8 vector element (+1.0 == 256)
//   ddr_address_t : DDR beat address
//   ddr_data_t    : one DDR read beat, packed 2-bit weights in the low bits
//   ternary_t     : 2-bit weight code (ZERO/POS/NEG, RSVD treated as zero)
//   state_t       : controller states of ternary_matvec_lanes
package config_pkg;

  localparam int FP_W       = 16;
  localparam int DDR_ADDR_W = 32;
  localparam int DDR_DATA_W = 64;
  localparam int TERNARY_W  = 2;

  typedef logic signed [FP_W-1:0]  fixed_point_t;
  typedef logic [DDR_ADDR_W-1:0]   ddr_address_t;
  typedef logic [DDR_DATA_W-1:0]   ddr_data_t;

  localparam fixed_point_t FP_MAX = 16'sh7FFF;
  localparam fixed_point_t FP_MIN = 16'sh8000;

  typedef enum logic [TERNARY_W-1:0] {
    ZERO = 2'b00,
    POS  = 2'b01,
    RSVD = 2'b10,
    NEG  = 2'b11
  } ternary_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_REQ,
    ST_WAIT,
    ST_WRITE
  } state_t;

endpackage

// File: rtl/ternary_mac_lanes.sv
// Combinational LANES-wide ternary multiply-accumulate.
//   i_w   : LANES packed 2-bit weight codes, lane k in bits [2k+1:2k]
//   i_x   : LANES packed fixed-point operands, lane k in bits [16k+15:16k]
//   o_sum : exact signed sum of all lane products
// Each product is 0, +x or -x, so one extra bit covers -(-32768); log2(LANES)
// more bits make the lane sum exact.
module ternary_mac_lanes
  import config_pkg::*;
#(
  parameter int LANES = 8,
  parameter int SUM_W = FP_W + 1 + $clog2(LANES)
) (
  input  logic [TERNARY_W*LANES-1:0] i_w,
  input  logic [FP_W*LANES-1:0]      i_x,
  output logic signed [SUM_W-1:0]    o_sum
);

  logic signed [FP_W:0] w_prod [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
    ternary_t             w_code;
    logic signed [FP_W:0] w_x_ext;
    assign w_code  = ternary_t'(i_w[gi*TERNARY_W +: TERNARY_W]);
    assign w_x_ext = {i_x[gi*FP_W + FP_W - 1], i_x[gi*FP_W +: FP_W]};
    // RSVD behaves like ZERO.
    assign w_prod[gi] = (w_code == POS) ? w_x_ext :
                        (w_code == NEG) ? -w_x_ext : '0;
  end

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      o_sum = o_sum + SUM_W'(w_prod[k]);
    end
  end

endmodule

// File: rtl/ternary_matvec_lanes.sv
// Ternary matrix-vector unit: y = W*x, W is DIM x DIM ternary, x/y fixed-point.
// Snapshots x from vector memory, streams packed weights from DDR (LANES per
// beat, one outstanding read), accumulates LANES products per beat and writes
// y[r] back to vector memory row r.
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   in_valid_i / in_ready_o    start handshake (ready only in IDLE)
//   matrix_memory_address_i    base beat address of row-major packed W
//   done_o                     pulse coincident with the final write
//   vector_w_en/addr/data_o    vector memory write port
//   vector_r_addr_o / _data_i  vector memory read port, data one cycle later
//   ddr_address_o, ddr_r_en_o  DDR beat request
//   ddr_r_data_i, ddr_r_valid_i DDR read response
// Build option: define TERNARY_MATVEC_SATURATE_EN to clamp y to the
// fixed-point range; otherwise y is the two's-complement wrap of the sum.
module ternary_matvec_lanes
  import config_pkg::*;
#(
  parameter int DIM     = 16,
  parameter int LANES   = 8,
  parameter int GUARD_W = $clog2(DIM) + 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  output logic                    in_ready_o,
  input  logic                    in_valid_i,
  input  logic [DDR_ADDR_W-1:0]   matrix_memory_address_i,
  output logic                    done_o,
  output logic                    vector_w_en_o,
  output logic [$clog2(DIM)-1:0]  vector_w_addr_o,
  output logic [FP_W-1:0]         vector_w_data_o,
  output logic [$clog2(DIM)-1:0]  vector_r_addr_o,
  input  logic [FP_W-1:0]         vector_r_data_i,
  output logic [DDR_ADDR_W-1:0]   ddr_address_o,
  output logic                    ddr_r_en_o,
  input  logic [DDR_DATA_W-1:0]   ddr_r_data_i,
  input  logic                    ddr_r_valid_i
);

  localparam int BEATS = DIM / LANES;
  localparam int RW    = $clog2(DIM);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = $clog2(DIM + 1);
  localparam int ACC_W = FP_W + GUARD_W;
  localparam int SUM_W = FP_W + 1 + $clog2(LANES);

  state_t                   r_state, w_state_next;
  logic [DDR_ADDR_W-1:0]    r_base;
  logic [RW-1:0]            r_row;
  logic [BW-1:0]            r_beat;
  logic [IW-1:0]            r_idx;
  logic signed [FP_W-1:0]   r_xbuf [DIM];
  logic signed [ACC_W-1:0]  r_acc;

  logic [LANES*FP_W-1:0]    w_x_lanes;
  logic signed [SUM_W-1:0]  w_mac_sum;
  logic signed [FP_W-1:0]   w_result;
  logic [RW-1:0]            w_cap_idx;
  logic                     w_last_beat, w_last_row, w_load_done;

  assign w_last_beat = (r_beat == BW'(BEATS - 1));
  assign w_last_row  = (r_row == RW'(DIM - 1));
  assign w_load_done = (r_idx == IW'(DIM));
  // Read data lags the address by one cycle, so cycle i captures x[i-1].
  assign w_cap_idx   = RW'(r_idx - 1'b1);

  // Lane k of beat b multiplies x[b*LANES + k].
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign w_x_lanes[gi*FP_W +: FP_W] = r_xbuf[RW'(int'(r_beat) * LANES + gi)];
  end

  ternary_mac_lanes #(
    .LANES (LANES),
    .SUM_W (SUM_W)
  ) u_mac (
    .i_w   (ddr_r_data_i[TERNARY_W*LANES-1:0]),
    .i_x   (w_x_lanes),
    .o_sum (w_mac_sum)
  );

  if (TERNARY_W * LANES < DDR_DATA_W) begin : g_unused
    logic w_unused_ddr;
    assign w_unused_ddr = ^ddr_r_data_i[DDR_DATA_W-1:TERNARY_W*LANES];
  end

`ifdef TERNARY_MATVEC_SATURATE_EN
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(FP_MAX);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(FP_MIN);
  always_comb begin
    if (r_acc > ACC_MAX)      w_result = FP_MAX;
    else if (r_acc < ACC_MIN) w_result = FP_MIN;
    else                      w_result = r_acc[FP_W-1:0];
  end
`else
  assign w_result = r_acc[FP_W-1:0];
`endif

  always_comb begin
    w_state_next  = r_state;
    in_ready_o    = 1'b0;
    done_o        = 1'b0;
    vector_w_en_o = 1'b0;
    ddr_r_en_o    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) w_state_next = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_load_done) w_state_next = ST_REQ;
      end
      ST_REQ: begin
        ddr_r_en_o   = 1'b1;
        w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (ddr_r_valid_i) w_state_next = w_last_beat ? ST_WRITE : ST_REQ;
      end
      ST_WRITE: begin
        vector_w_en_o = 1'b1;
        if (w_last_row) begin
          done_o       = 1'b1;
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_REQ;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign vector_r_addr_o = (r_state == ST_LOAD) ? r_idx[RW-1:0] : '0;
  assign vector_w_addr_o = (r_state == ST_WRITE) ? r_row : '0;
  assign vector_w_data_o = (r_state == ST_WRITE) ? w_result : '0;
  // Address is only meaningful while a beat is requested or awaited.
  assign ddr_address_o   = (r_state == ST_REQ || r_state == ST_WAIT) ?
                           r_base + DDR_ADDR_W'(r_row) * DDR_ADDR_W'(BEATS)
                                  + DDR_ADDR_W'(r_beat) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_base  <= '0;
      r_row   <= '0;
      r_beat  <= '0;
      r_idx   <= '0;
      r_acc   <= '0;
      for (int k = 0; k < DIM; k++) r_xbuf[k] <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        ST_IDLE: begin
          if (in_valid_i) begin
            r_base <= matrix_memory_address_i;
            r_row  <= '0;
            r_beat <= '0;
            r_idx  <= '0;
            r_acc  <= '0;
          end
        end
        ST_LOAD: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx != '0) r_xbuf[w_cap_idx] <= vector_r_data_i;
        end
        ST_WAIT: begin
          if (ddr_r_valid_i) begin
            r_acc <= r_acc + ACC_W'(w_mac_sum);
            if (!w_last_beat) r_beat <= r_beat + 1'b1;
          end
        end
        ST_WRITE: begin
          r_acc  <= '0;
          r_beat <= '0;
          if (!w_last_row) r_row <= r_row + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ternary_matvec_lanes.sv
`timescale 1ns/1ps
module tb_ternary_matvec_lanes;
  import config_pkg::*;

  localparam int DIM   = 16;
  localparam int LANES = 8;
  localparam int BEATS = DIM / LANES;
  localparam int NW    = DIM * BEATS;
  localparam logic [31:0] BASE = 32'h0000_4A00;

  logic        clk = 1'b0;
  logic        rst_i, in_valid_i, in_ready_o, done_o;
  logic        vector_w_en_o, ddr_r_en_o, ddr_r_valid_i;
  logic [3:0]  vector_w_addr_o, vector_r_addr_o;
  logic [15:0] vector_w_data_o, vector_r_data_i;
  logic [31:0] matrix_memory_address_i, ddr_address_o;
  logic [63:0] ddr_r_data_i;

  ternary_matvec_lanes #(.DIM(DIM), .LANES(LANES)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst_i),
    .in_ready_o              (in_ready_o),
    .in_valid_i              (in_valid_i),
    .matrix_memory_address_i (matrix_memory_address_i),
    .done_o                  (done_o),
    .vector_w_en_o           (vector_w_en_o),
    .vector_w_addr_o         (vector_w_addr_o),
    .vector_w_data_o         (vector_w_data_o),
    .vector_r_addr_o         (vector_r_addr_o),
    .vector_r_data_i         (vector_r_data_i),
    .ddr_address_o           (ddr_address_o),
    .ddr_r_en_o              (ddr_r_en_o),
    .ddr_r_data_i            (ddr_r_data_i),
    .ddr_r_valid_i           (ddr_r_valid_i)
  );

  initial forever #5 clk = ~clk;

  // Stimulus and reference state
  logic [1:0]         wcode [DIM][DIM];
  logic signed [15:0] xvec  [DIM];
  logic signed [15:0] exp_y [DIM];
  logic signed [15:0] vmem  [DIM];
  logic [63:0]        ddr_words [NW];
  int  n_cmp = 0, n_fail = 0;
  bit  armed = 0, quiet = 0;
  int  wr_ptr = 0;
  int  t_min = 1, t_max = 1;
  bit  stray_en = 0;
  bit  ddr_pend = 0;
  int  ddr_cnt = 0, req_n = 0, ddr_idx = 0;
  logic [63:0] ddr_word = '0;
  logic [3:0]  vm_raddr = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // y[r] straight from the definition: sum of +x / -x per weight code.
  function automatic logic signed [15:0] model_row(input int r);
    longint s = 0;
    for (int c = 0; c < DIM; c++) begin
      if (wcode[r][c] == 2'b01)      s += xvec[c];
      else if (wcode[r][c] == 2'b11) s -= xvec[c];
    end
`ifdef TERNARY_MATVEC_SATURATE_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic build_ddr();
    for (int r = 0; r < DIM; r++) begin
      for (int b = 0; b < BEATS; b++) begin
        logic [63:0] wd;
        wd = {$urandom, $urandom};
        for (int k = 0; k < LANES; k++) wd[2*k +: 2] = wcode[r][b*LANES + k];
        ddr_words[r*BEATS + b] = wd;
      end
    end
  endtask

  // Vector memory with one-cycle registered read
  initial begin
    vector_r_data_i = '0;
    forever begin
      @(posedge clk); #1;
      vector_r_data_i = vmem[vm_raddr];
      vm_raddr = vector_r_addr_o;
      if (vector_w_en_o) vmem[vector_w_addr_o] = vector_w_data_o;
    end
  end

  // DDR responder: one request in flight, latency t_min..t_max, optional stray valids
  initial begin
    ddr_r_valid_i = 1'b0;
    ddr_r_data_i  = '0;
    forever begin
      @(posedge clk); #1;
      ddr_r_valid_i = 1'b0;
      ddr_r_data_i  = {$urandom, $urandom};
      if (ddr_pend) begin
        ddr_cnt--;
        if (ddr_cnt == 0) begin
          ddr_r_valid_i = 1'b1;
          ddr_r_data_i  = ddr_word;
          ddr_pend      = 1'b0;
        end
      end else if (stray_en && $urandom_range(2, 0) == 0) begin
        ddr_r_valid_i = 1'b1;
      end
      if (ddr_r_en_o) begin
        check("ddr_addr", ddr_address_o, BASE + req_n);
        check("one_outstanding", ddr_pend, 0);
        ddr_idx  = int'(ddr_address_o - BASE);
        ddr_word = (ddr_idx >= 0 && ddr_idx < NW) ? ddr_words[ddr_idx] : '0;
        ddr_pend = 1'b1;
        ddr_cnt  = $urandom_range(t_max, t_min);
        req_n++;
      end
    end
  end

  // Compare process: every write checked against the model
  initial begin
    forever begin
      @(negedge clk);
      if (vector_w_en_o) begin
        if (!armed || wr_ptr >= DIM) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: got row %0d expected no write at %0t",
                   vector_w_addr_o, $time);
        end else begin
          $display("write row %0d data %0d done %0d", vector_w_addr_o,
                   $signed(vector_w_data_o), done_o);
          check("w_addr", vector_w_addr_o, wr_ptr);
          check("w_data", $signed(vector_w_data_o), exp_y[wr_ptr]);
          check("done_flag", done_o, (wr_ptr == DIM - 1) ? 1 : 0);
          wr_ptr++;
        end
      end else if (done_o) begin
        n_cmp++; n_fail++;
        $display("FAIL done_without_write: got done 1 expected 0 at %0t", $time);
      end
      if (quiet && (ddr_r_en_o || vector_w_en_o)) begin
        n_cmp++; n_fail++;
        $display("FAIL quiet_after_reset: got en %0d/%0d expected 0/0", ddr_r_en_o, vector_w_en_o);
      end
    end
  end

  task automatic run(input string name, input int tmin, input int tmax,
                     input bit stray, input bit hold);
    int cyc;
    bit got;
    t_min = tmin; t_max = tmax; stray_en = stray;
    build_ddr();
    for (int i = 0; i < DIM; i++) vmem[i] = xvec[i];
    for (int r = 0; r < DIM; r++) exp_y[r] = model_row(r);
    wr_ptr = 0; req_n = 0; armed = 1;
    @(negedge clk);
    check("ready_idle", in_ready_o, 1);
    matrix_memory_address_i = BASE;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    if (!hold) in_valid_i = 1'b0;
    check("busy_not_ready", in_ready_o, 0);
    cyc = 0; got = 0;
    while (!got && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (done_o) got = 1;
    end
    in_valid_i = 1'b0;
    #1;
    check("done_seen", got, 1);
    check("write_count", wr_ptr, DIM);
    if (tmin == tmax) check("latency", cyc, DIM + 1 + DIM*BEATS*(1 + tmin) + DIM);
    @(negedge clk);
    check("ready_after_done", in_ready_o, 1);
    repeat (6) @(negedge clk);
    armed = 0;
    for (int i = 0; i < DIM; i++) check("vmem_y", vmem[i], exp_y[i]);
    $display("run %s: %0d cycles to done", name, cyc);
  endtask

  initial begin
    int cyc;
    bit got;
    rst_i = 1'b1; in_valid_i = 1'b0; matrix_memory_address_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready_o, 1);
    check("rst_done", done_o, 0);
    check("rst_w_en", vector_w_en_o, 0);
    check("rst_w_addr", vector_w_addr_o, 0);
    check("rst_w_data", vector_w_data_o, 0);
    check("rst_r_addr", vector_r_addr_o, 0);
    check("rst_ddr_en", ddr_r_en_o, 0);
    check("rst_ddr_addr", ddr_address_o, 0);
    rst_i = 1'b0;

    // Identity: y = x
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wcode[r][c] = (r == c) ? 2'b01 : 2'b00;
    for (int i = 0; i < DIM; i++) xvec[i] = 16'(i);
    run("identity", 2, 2, 0, 0);
    check("pin_identity_y5", exp_y[5], 5);
    check("pin_identity_y15", exp_y[15], 15);

    // All -1 weights, x = +1.0 (256): y = -16.0
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wcode[r][c] = 2'b11;
    for (int i = 0; i < DIM; i++) xvec[i] = 16'sd256;
    run("all_neg", 1, 1, 0, 0);
    check("pin_neg_y0", exp_y[0], -4096);

    // All zero weights
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wcode[r][c] = 2'b00;
    for (int i = 0; i < DIM; i++) xvec[i] = 16'($urandom);
    run("all_zero", 3, 3, 0, 0);
    check("pin_zero_y7", exp_y[7], 0);

    // Row 0 all +1, x all max: overflow of the 16-bit range
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wcode[r][c] = (r == 0) ? 2'b01 : 2'b00;
    for (int i = 0; i < DIM; i++) xvec[i] = 16'sh7FFF;
    run("row0_max", 1, 1, 0, 0);
`ifdef TERNARY_MATVEC_SATURATE_EN
    check("pin_sat_y0", exp_y[0], 32767);
`else
    check("pin_wrap_y0", exp_y[0], -16);
`endif
    check("pin_max_y1", exp_y[1], 0);

    // Reserved code everywhere behaves as zero
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wcode[r][c] = 2'b10;
    for (int i = 0; i < DIM; i++) xvec[i] = 16'($urandom);
    run("reserved", 2, 2, 0, 0);
    check("pin_rsvd_y3", exp_y[3], 0);

    // Random W/x, random DDR latency, stray valids
    for (int t = 0; t < 2; t++) begin
      for (int r = 0; r < DIM; r++)
        for (int c = 0; c < DIM; c++) wcode[r][c] = 2'($urandom);
      for (int i = 0; i < DIM; i++) xvec[i] = 16'($urandom);
      run("random", 1, 5, 1, 0);
    end

    // in_valid held high through the run: exactly one run
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) wcode[r][c] = 2'($urandom);
    for (int i = 0; i < DIM; i++) xvec[i] = 16'($urandom_range(4095, 0)) - 16'sd2048;
    run("hold_valid", 3, 3, 0, 1);

    // Reset while waiting on DDR: no writes or requests afterwards
    t_min = 5; t_max = 5; stray_en = 0;
    build_ddr();
    for (int i = 0; i < DIM; i++) vmem[i] = xvec[i];
    wr_ptr = 0; req_n = 0; armed = 0;
    @(negedge clk);
    matrix_memory_address_i = BASE;
    in_valid_i = 1'b1;
    @(posedge clk); #1;
    in_valid_i = 1'b0;
    cyc = 0; got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ddr_r_en_o) got = 1;
    end
    check("saw_first_req", got, 1);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    quiet = 1;
    repeat (30) @(negedge clk);
    quiet = 0;
    check("rst_wait_ready", in_ready_o, 1);
    check("rst_wait_no_writes", wr_ptr, 0);
    check("rst_wait_ddr_addr", ddr_address_o, 0);
    $display("run reset_in_wait: reset applied after %0d cycles", cyc + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
